// File: rtl/serial_sub.sv
// serial_sub: bit-serial unsigned subtractor, diff = a - b over WIDTH bits,
// one full-subtractor step per clock, LSB first.
// Optional build macro: SERIAL_SUB_SATURATE_EN clamps a negative result to zero
// (borrow_out still reports the underflow; latency is unchanged).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready=1, waiting for start; operands captured on accept
// SHIFT | one bit per cycle through the two half-subtractor stages
// DONE  | single cycle, valid=1, diff/borrow_out just updated
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic             borrow;
    logic [CW-1:0]    count;
    logic             x;
    logic             d;
    logic             bout;

    // Full-subtractor step on the current LSBs; result bit enters at the MSB.
    always_comb begin
        x        = a_sh[0] ^ b_sh[0];
        d        = x ^ borrow;
        bout     = (~a_sh[0] & b_sh[0]) | (~x & borrow);
        res_next = res >> 1;
        res_next[WIDTH-1] = d;
    end

    // Sequencer and datapath registers; outputs are loaded on the step
    // that completes the last bit so they are valid throughout DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ready      <= 1'b1;
            valid      <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            a_sh       <= '0;
            b_sh       <= '0;
            res        <= '0;
            borrow     <= 1'b0;
            count      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    valid <= 1'b0;
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        res    <= '0;
                        borrow <= 1'b0;
                        count  <= '0;
                        ready  <= 1'b0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res    <= res_next;
                    borrow <= bout;
                    count  <= count + CW'(1);
                    if (count == LAST) begin
`ifdef SERIAL_SUB_SATURATE_EN
                        diff <= bout ? '0 : res_next;
`else
                        diff <= res_next;
`endif
                        borrow_out <= bout;
                        valid      <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    valid <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    valid <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub: an 8-bit and a 1-bit instance share the clock.
// Expected results are pushed to a queue on stimulus and popped on valid.
module tb_serial_sub;

    logic       clk;
    logic       rst_n;
    logic       start8, start1;
    logic [7:0] a8, b8;
    logic [0:0] a1, b1;
    logic       ready8, valid8, bo8;
    logic [7:0] diff8;
    logic       ready1, valid1, bo1;
    logic [0:0] diff1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] d;
        logic       bo;
    } exp_t;

    exp_t sb[$];

    serial_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .ready(ready8), .valid(valid8), .diff(diff8), .borrow_out(bo8)
    );

    serial_sub #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .ready(ready1), .valid(valid1), .diff(diff1), .borrow_out(bo1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input int w);
        exp_t e;
        logic [7:0] mask;
        mask = (w == 8) ? 8'hFF : 8'h01;
        e.d  = (a - b) & mask;
        e.bo = ((a & mask) < (b & mask));
`ifdef SERIAL_SUB_SATURATE_EN
        if (e.bo) e.d = 8'h00;
`endif
        return e;
    endfunction

    // Called at the negedge just after the accepting edge; counts negedges to valid.
    task automatic wait_and_check8(input string name, input int exp_lat);
        int         cnt;
        bit         stable;
        bit         rdy_low;
        logic [7:0] held_d;
        logic       held_b;
        exp_t       e;
        cnt = 1; stable = 1; rdy_low = 1;
        held_d = diff8; held_b = bo8;
        while (!valid8 && cnt < 40) begin
            if (diff8 !== held_d || bo8 !== held_b) stable = 0;
            if (ready8 !== 1'b0) rdy_low = 0;
            @(negedge clk);
            cnt++;
        end
        if (ready8 !== 1'b0) rdy_low = 0;
        checks++;
        if (cnt !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, cnt, exp_lat);
        end
        checks++;
        if (!stable || !rdy_low) begin
            errors++;
            $display("FAIL %s hold: diff_stable=%0d ready_low=%0d expected 1 1", name, stable, rdy_low);
        end
        if (sb.size() == 0) begin
            errors++; checks++;
            $display("FAIL %s scoreboard: got empty queue expected entry", name);
        end else begin
            e = sb.pop_front();
            checks++;
            if (diff8 !== e.d || bo8 !== e.bo) begin
                errors++;
                $display("FAIL %s result: got diff=%0d bo=%0b expected diff=%0d bo=%0b",
                         name, diff8, bo8, e.d, e.bo);
            end
        end
        @(negedge clk);
        checks++;
        if (valid8 !== 1'b0 || ready8 !== 1'b1) begin
            errors++;
            $display("FAIL %s after done: got valid=%0b ready=%0b expected 0 1", name, valid8, ready8);
        end
    endtask

    task automatic run_op8(input string name, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        a8 = a; b8 = b; start8 = 1'b1;
        sb.push_back(model(a, b, 8));
        @(negedge clk);
        start8 = 1'b0;
        a8 = ~a; b8 = ~b;
        wait_and_check8(name, 9);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++;
        if (ready8 !== 1'b1 || valid8 !== 1'b0 || diff8 !== 8'h00 || bo8 !== 1'b0) begin
            errors++;
            $display("FAIL reset: got ready=%0b valid=%0b diff=%0h bo=%0b expected 1 0 0 0",
                     ready8, valid8, diff8, bo8);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        run_op8("sub_200_55", 8'd200, 8'd55);
        run_op8("sub_5_10", 8'd5, 8'd10);
    endtask

    task automatic test_midop_reset;
        int seen;
        @(negedge clk);
        a8 = 8'd77; b8 = 8'd3; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ready8 !== 1'b1 || valid8 !== 1'b0 || diff8 !== 8'h00 || bo8 !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset: got ready=%0b valid=%0b diff=%0h bo=%0b expected 1 0 0 0",
                     ready8, valid8, diff8, bo8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (valid8) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midop_novalid: got %0d pulses expected 0", seen);
        end
        run_op8("after_reset", 8'd100, 8'd1);
    endtask

    task automatic test_boundaries;
        run_op8("sub_00_ff", 8'h00, 8'hFF);
        run_op8("sub_5a_5a", 8'h5A, 8'h5A);
        run_op8("sub_ff_00", 8'hFF, 8'h00);
        for (int i = 0; i < 3; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run_op8("random", ra, rb);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        a8 = 8'd30; b8 = 8'd12; start8 = 1'b1;
        sb.push_back(model(8'd30, 8'd12, 8));
        @(negedge clk);
        checks++;
        if (ready8 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: got ready=%0b expected 0", ready8);
        end
        begin
            int cnt;
            cnt = 1;
            while (!valid8 && cnt < 40) begin
                a8 = 8'($urandom_range(0, 255));
                b8 = 8'($urandom_range(0, 255));
                @(negedge clk);
                cnt++;
            end
            checks++;
            if (cnt !== 9) begin
                errors++;
                $display("FAIL b2b_latency: got %0d expected 9", cnt);
            end
        end
        begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (diff8 !== e.d || bo8 !== e.bo) begin
                errors++;
                $display("FAIL b2b_first: got diff=%0d bo=%0b expected diff=%0d bo=%0b",
                         diff8, bo8, e.d, e.bo);
            end
        end
        a8 = 8'd9; b8 = 8'd4;
        sb.push_back(model(8'd9, 8'd4, 8));
        @(negedge clk);
        checks++;
        if (ready8 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle: got ready=%0b expected 1", ready8);
        end
        @(negedge clk);
        start8 = 1'b0;
        checks++;
        if (ready8 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_accept: got ready=%0b expected 0", ready8);
        end
        wait_and_check8("b2b_second", 9);
    endtask

    task automatic test_width1;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            exp_t       e;
            int         cnt;
            ab = 2'(i);
            @(negedge clk);
            a1 = ab[1]; b1 = ab[0]; start1 = 1'b1;
            sb.push_back(model({7'b0, ab[1]}, {7'b0, ab[0]}, 1));
            @(negedge clk);
            start1 = 1'b0;
            cnt = 1;
            while (!valid1 && cnt < 20) begin
                @(negedge clk);
                cnt++;
            end
            e = sb.pop_front();
            checks++;
            if (cnt !== 2 || diff1 !== e.d[0] || bo1 !== e.bo) begin
                errors++;
                $display("FAIL w1_case%0d: got lat=%0d diff=%0b bo=%0b expected lat=2 diff=%0b bo=%0b",
                         i, cnt, diff1, bo1, e.d[0], e.bo);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        start8 = 1'b0; start1 = 1'b0;
        a8 = '0; b8 = '0; a1 = '0; b1 = '0;
        test_reset();
        test_basic();
        test_midop_reset();
        test_boundaries();
        test_back_to_back();
        test_width1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
